priority_encoder_arbiter: RTL and testbench

Shares one `priority_encoder` instance between `REQ_NUM` requesters. Requesters present words with a valid/ready handshake, and the block grants one per cycle in round-robin order. It forwards the granted word to the encoder and tags it with the requester ID. When the encoder result returns, the block routes it back to the originating requester. It sits in front of the encoder in the top level and replaces direct wiring of a single source to the encoder.

---
 rtl/priority_encoder_pkg.sv | 11 +
 rtl/pe_arb_tag_fifo.sv | 56 +++++
 rtl/priority_encoder_arbiter.sv | 146 ++++++++++++++
 tb/tb_priority_encoder_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_pkg.sv
// Shared constants and types for the priority-encoder arbiter slice.
package priority_encoder_pkg;

  localparam int WIDTH_DFLT     = 50;
  localparam int REQ_NUM_DFLT   = 4;
  localparam int TAG_DEPTH_DFLT = 4;
  localparam int REQ_ID_W       = $clog2(REQ_NUM_DFLT);

  typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/pe_arb_tag_fifo.sv
// Synchronous FIFO of requester IDs; holds the owner of each word in flight.
module pe_arb_tag_fifo #(
  parameter int ID_W  = 2,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            srst_i,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head_id,
  output logic            empty,
  output logic            full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ID_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   fill;
  logic            do_push;
  logic            do_pop;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (fill == '0);
  assign full    = (fill == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   fill <= fill + CW'(1);
        2'b01:   fill <= fill - CW'(1);
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/priority_encoder_arbiter.sv
// Round-robin arbiter sharing one priority encoder among REQ_NUM requesters.
// Optional sticky protocol-error output err_o is built when PE_ARB_ERR_EN is defined.
module priority_encoder_arbiter
  import priority_encoder_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DFLT,
  parameter int REQ_NUM   = REQ_NUM_DFLT,
  parameter int TAG_DEPTH = TAG_DEPTH_DFLT
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [REQ_NUM*WIDTH-1:0] req_data_i,
  input  logic [REQ_NUM-1:0]       req_val_i,
  output logic [REQ_NUM-1:0]       req_ready_o,
  output logic [WIDTH-1:0]         enc_data_o,
  output logic                     enc_data_val_o,
  input  logic [WIDTH-1:0]         enc_data_left_i,
  input  logic [WIDTH-1:0]         enc_data_right_i,
  input  logic                     enc_data_val_i,
  output logic [WIDTH-1:0]         rsp_left_o,
  output logic [WIDTH-1:0]         rsp_right_o,
  output logic [REQ_NUM-1:0]       rsp_val_o
`ifdef PE_ARB_ERR_EN
  ,
  output logic                     err_o
`endif
);

  localparam int ID_W = $clog2(REQ_NUM);
  localparam int CW   = $clog2(TAG_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TAG_DEPTH);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    idx;
  logic [ID_W-1:0]    head_id;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   gnt_data_p0;
  logic               gnt_found;
  logic               eligible;
  logic               grant;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;

  logic [WIDTH-1:0]   enc_data_p1;
  logic               vld_p1;
  logic [WIDTH-1:0]   rsp_left_p2;
  logic [WIDTH-1:0]   rsp_right_p2;
  logic [REQ_NUM-1:0] vld_p2;

  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
    return (id == ID_W'(REQ_NUM - 1)) ? '0 : id + ID_W'(1);
  endfunction

  // Stage p0: search from ptr upward with wrap for the first valid requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      idx = ID_W'((int'(ptr) + k) % REQ_NUM);
      if (!gnt_found && req_val_i[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  always_comb begin
    gnt_data_p0 = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (gnt_id == ID_W'(k)) gnt_data_p0 = req_data_i[k*WIDTH +: WIDTH];
    end
  end

  // A same-cycle pop does not free a slot: eligibility looks at registered cnt only.
  assign eligible    = (cnt < CNT_MAX);
  assign grant       = eligible & gnt_found;
  assign pop         = enc_data_val_i & ~fifo_empty;
  assign req_ready_o = grant ? (REQ_NUM'(1) << gnt_id) : '0;

  pe_arb_tag_fifo #(
    .ID_W  (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .push    (grant & ~fifo_full),
    .push_id (gnt_id),
    .pop     (pop),
    .head_id (head_id),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ptr    <= '0;
      cnt    <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= '0;
    end else begin
      vld_p1 <= grant;
      vld_p2 <= pop ? (REQ_NUM'(1) << head_id) : '0;
      if (grant) ptr <= rr_next(gnt_id);
      case ({grant, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Stage p1 (towards encoder) and p2 (response); both clear on reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      enc_data_p1  <= '0;
      rsp_left_p2  <= '0;
      rsp_right_p2 <= '0;
    end else begin
      if (grant) enc_data_p1 <= gnt_data_p0;
      if (pop) begin
        rsp_left_p2  <= enc_data_left_i;
        rsp_right_p2 <= enc_data_right_i;
      end
    end
  end

  assign enc_data_o     = enc_data_p1;
  assign enc_data_val_o = vld_p1;
  assign rsp_left_o     = rsp_left_p2;
  assign rsp_right_o    = rsp_right_p2;
  assign rsp_val_o      = vld_p2;

`ifdef PE_ARB_ERR_EN
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      err_o <= 1'b0;
    end else if ((enc_data_val_i && fifo_empty) || (grant && (cnt == CNT_MAX))) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_priority_encoder_arbiter.sv
// Randomized bench for priority_encoder_arbiter with a queue-based reference model and encoder model.
module tb_priority_encoder_arbiter;
  import priority_encoder_pkg::*;

  localparam int W = 50;
  localparam int N = 4;
  localparam int D = 4;

  logic           clk_i = 1'b0;
  logic           srst_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   req_val_i;
  logic [N-1:0]   req_ready_o;
  logic [W-1:0]   enc_data_o;
  logic           enc_data_val_o;
  logic [W-1:0]   enc_data_left_i;
  logic [W-1:0]   enc_data_right_i;
  logic           enc_data_val_i;
  logic [W-1:0]   rsp_left_o;
  logic [W-1:0]   rsp_right_o;
  logic [N-1:0]   rsp_val_o;
`ifdef PE_ARB_ERR_EN
  logic           err_o;
`endif

  always #5 clk_i = ~clk_i;

  priority_encoder_arbiter #(.WIDTH(W), .REQ_NUM(N), .TAG_DEPTH(D)) dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .req_data_i       (req_data_i),
    .req_val_i        (req_val_i),
    .req_ready_o      (req_ready_o),
    .enc_data_o       (enc_data_o),
    .enc_data_val_o   (enc_data_val_o),
    .enc_data_left_i  (enc_data_left_i),
    .enc_data_right_i (enc_data_right_i),
    .enc_data_val_i   (enc_data_val_i),
    .rsp_left_o       (rsp_left_o),
    .rsp_right_o      (rsp_right_o),
    .rsp_val_o        (rsp_val_o)
`ifdef PE_ARB_ERR_EN
    ,
    .err_o            (err_o)
`endif
  );

  int total = 0;
  int bad   = 0;
  int lat   = 2;

  // Encoder model: history of what the arbiter sent, replayed lat cycles later.
  logic         hist_v [8];
  logic [W-1:0] hist_d [8];

  // Reference model state.
  int           m_ptr = 0;
  int           inflight [$];
  logic         m_enc_val  = 1'b0;
  logic [W-1:0] m_enc_data = '0;
  logic [N-1:0] m_rsp_val  = '0;
  logic [W-1:0] m_left     = '0;
  logic [W-1:0] m_right    = '0;
  logic         m_err      = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] f_left(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) if (x[i]) r = '0 | (W'(1) << i);
    return r;
  endfunction

  function automatic logic [W-1:0] f_right(input logic [W-1:0] x);
    return x & (~x + W'(1));
  endfunction

  function automatic logic [N*W-1:0] rnd_data();
    logic [N*W-1:0] d;
    logic [63:0]    t;
    d = '0;
    for (int i = 0; i < N; i++) begin
      t = {$urandom(), $urandom()} & {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) t = '0;
      d[i*W +: W] = t[W-1:0];
    end
    return d;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check ready, advance model.
  task automatic step(input logic [N-1:0] vals, input logic [N*W-1:0] data,
                      input bit orphan, input bit rst);
    logic [N-1:0] exp_rdy;
    logic [W-1:0] ein;
    int           g;
    int           sz;
    @(negedge clk_i);
    chk("enc_data_val", enc_data_val_o, m_enc_val);
    chk("enc_data", enc_data_o, m_enc_data);
    chk("rsp_val", rsp_val_o, m_rsp_val);
    if (m_rsp_val != '0) begin
      chk("rsp_left", rsp_left_o, m_left);
      chk("rsp_right", rsp_right_o, m_right);
    end
`ifdef PE_ARB_ERR_EN
    chk("err", err_o, m_err);
`endif
    for (int k = 7; k > 0; k--) begin
      hist_v[k] = hist_v[k-1];
      hist_d[k] = hist_d[k-1];
    end
    hist_v[0] = enc_data_val_o;
    hist_d[0] = enc_data_o;

    req_val_i  = vals;
    req_data_i = data;
    srst_i     = rst;
    if (orphan) begin
      enc_data_val_i = 1'b1;
      ein            = 50'h3_0000_0001_0400;
    end else begin
      enc_data_val_i = hist_v[lat];
      ein            = hist_d[lat];
    end
    enc_data_left_i  = f_left(ein);
    enc_data_right_i = f_right(ein);
    #1;

    sz      = inflight.size();
    g       = -1;
    exp_rdy = '0;
    if (sz < D) begin
      for (int k = 0; k < N; k++) if (g < 0 && vals[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready_o, exp_rdy);

    if (rst) begin
      inflight.delete();
      m_ptr = 0; m_enc_val = 1'b0; m_enc_data = '0; m_rsp_val = '0;
      m_left = '0; m_right = '0; m_err = 1'b0;
      for (int k = 0; k < 8; k++) begin
        hist_v[k] = 1'b0;
        hist_d[k] = '0;
      end
    end else begin
      m_rsp_val = '0;
      if (enc_data_val_i) begin
        if (sz > 0) begin
          m_rsp_val[inflight.pop_front()] = 1'b1;
          m_left  = enc_data_left_i;
          m_right = enc_data_right_i;
        end else begin
          m_err = 1'b1;
        end
      end
      if (g >= 0) begin
        m_enc_val  = 1'b1;
        m_enc_data = data[g*W +: W];
        m_ptr      = (g + 1) % N;
        inflight.push_back(g);
      end else begin
        m_enc_val = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, rnd_data(), 1'b0, 1'b0);
  endtask

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   v;
    for (int k = 0; k < 8; k++) begin
      hist_v[k] = 1'b0;
      hist_d[k] = '0;
    end
    srst_i = 1'b1; req_val_i = '0; req_data_i = '0;
    enc_data_val_i = 1'b0; enc_data_left_i = '0; enc_data_right_i = '0;
    repeat (2) @(posedge clk_i);
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0);
    chk("rst_enc_val", enc_data_val_o, 1'b0);
    chk("rst_enc_data", enc_data_o, '0);
    chk("rst_rsp_val", rsp_val_o, '0);

    // Single word from requester 1 with bits 3 and 5 set.
    d = '0;
    d[W +: W] = 50'h28;
    step(4'b0010, d, 1'b0, 1'b0);
    chk("single_ready", req_ready_o, 4'b0010);
    idle(3);
    chk("single_early", rsp_val_o, 4'b0000);
    idle(1);
    chk("single_rsp_val", rsp_val_o, 4'b0010);
    chk("single_left", rsp_left_o, 50'h20);
    chk("single_right", rsp_right_o, 50'h8);

    // Wrap-around: requester 2 wins, ptr lands on 3, then 0 beats 2.
    step(4'b0100, rnd_data(), 1'b0, 1'b0);
    step(4'b0101, rnd_data(), 1'b0, 1'b0);
    chk("wrap_ready0", req_ready_o, 4'b0001);
    step(4'b0101, rnd_data(), 1'b0, 1'b0);
    chk("wrap_ready2", req_ready_o, 4'b0100);
    idle(8);

    // All requesters valid continuously.
    for (int i = 0; i < 40; i++) step(4'b1111, rnd_data(), 1'b0, 1'b0);

    // Reset with three words in flight.
    idle(8);
    for (int i = 0; i < 3; i++) step(4'b1111, rnd_data(), 1'b0, 1'b0);
    step('0, rnd_data(), 1'b0, 1'b1);
    step(4'b1111, rnd_data(), 1'b0, 1'b0);
    chk("postrst_enc_val", enc_data_val_o, 1'b0);
    chk("postrst_rsp_val", rsp_val_o, '0);
    chk("postrst_enc_data", enc_data_o, '0);
    chk("postrst_ready", req_ready_o, 4'b0001);

    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) == 0) ? 4'b1111 : N'($urandom_range(0, 15));
      step(v, rnd_data(), 1'b0, 1'b0);
    end

    // Encoder latency too long for the tag depth: grants stall at cnt=TAG_DEPTH.
    idle(12);
    lat = 5;
    for (int i = 0; i < 4; i++) step(4'b1111, rnd_data(), 1'b0, 1'b0);
    step(4'b1111, rnd_data(), 1'b0, 1'b0);
    chk("stall_ready", req_ready_o, 4'b0000);
    for (int i = 0; i < 200; i++) begin
      v = ($urandom_range(0, 1) == 0) ? 4'b1111 : N'($urandom_range(0, 15));
      step(v, rnd_data(), 1'b0, 1'b0);
    end

    // Orphan response with nothing in flight.
    idle(12);
    step('0, rnd_data(), 1'b1, 1'b0);
    step('0, rnd_data(), 1'b0, 1'b0);
    chk("orphan_rsp_val", rsp_val_o, 4'b0000);
`ifdef PE_ARB_ERR_EN
    chk("orphan_err", err_o, 1'b1);
    idle(3);
    chk("orphan_err_held", err_o, 1'b1);
`endif
    step('0, rnd_data(), 1'b0, 1'b1);
    idle(4);
`ifdef PE_ARB_ERR_EN
    chk("err_cleared", err_o, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
